// File: rtl/sum_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_bcd_display_pkg
// Description : Shared types and constants for the sum-to-BCD display stage:
//               FSM state type, conversion geometry, active-low 7-segment
//               codes and the per-digit add-3 helper used by the converter.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_bcd_display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int unsigned c_DIGITS = 3;
    localparam int unsigned c_IN_W   = 9;
    localparam int unsigned c_ITER   = 9;
    localparam int unsigned c_CNT_W  = 4;
    localparam int unsigned c_BCD_W  = 4 * c_DIGITS;

    // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // after the next doubling, so pre-add 3 to carry it into the next digit.
    function automatic logic [3:0] add3_digit(input logic [3:0] i_d);
        return (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_bcd_display_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD digit to active-low 7-segment decoder.
//               Codes 10..15 map to a blank digit.
// Ports       : i_digit [3:0]  BCD digit
//               o_seg   [6:0]  {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import sum_bcd_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : sum_bcd_display
// Description : Converts a 9-bit binary sum into three BCD digits with a
//               sequential shift-add-3 engine (one bit per clock) and drives
//               three registered active-low 7-segment displays.
// Ports       : clk, reset      clock, synchronous active-high reset
//               value [8:0]     binary sum, captured when load is accepted
//               load            one-cycle conversion request (IDLE only)
//               busy            conversion in progress
//               done            one-cycle pulse, new digits valid
//               bcd [11:0]      {hundreds, tens, ones}
//               HEX2/HEX1/HEX0  hundreds/tens/ones segments, active-low
// Config      : SUM_DISPLAY_BLANK_EN - blank leading zeros on HEX2/HEX1
// Revision    : 1.0 - initial release
// ============================================================================
module sum_bcd_display
    import sum_bcd_display_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [c_IN_W-1:0]   value,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic [c_BCD_W-1:0]  bcd,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX0
);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);

`ifdef SUM_DISPLAY_BLANK_EN
    localparam logic [6:0] c_HEX_HI_RST = c_SEG_BLANK;
`else
    localparam logic [6:0] c_HEX_HI_RST = c_SEG_0;
`endif

    state_t               r_state;
    logic [c_IN_W-1:0]    r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [6:0]           r_hex2;
    logic [6:0]           r_hex1;
    logic [6:0]           r_hex0;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_next_scratch;
    logic [c_IN_W-1:0]    w_next_shift;
    logic                 w_unused_msb;
    logic [6:0]           w_seg2;
    logic [6:0]           w_seg1;
    logic [6:0]           w_seg0;
    logic [6:0]           w_hex2;
    logic [6:0]           w_hex1;
    logic [6:0]           w_hex0;

    // One iteration: correct every digit, then shift {scratch, shift} left.
    assign w_adj = {add3_digit(r_scratch[11:8]),
                    add3_digit(r_scratch[7:4]),
                    add3_digit(r_scratch[3:0])};
    assign w_next_scratch = {w_adj[c_BCD_W-2:0], r_shift[c_IN_W-1]};
    assign w_next_shift   = {r_shift[c_IN_W-2:0], 1'b0};
    // The top scratch bit is always zero for inputs below 1000.
    assign w_unused_msb   = w_adj[c_BCD_W-1];

    // Decoders look at the post-iteration scratch so the final iteration and
    // the display update land on the same edge.
    seg7_decode u_dec2 (.i_digit(w_next_scratch[11:8]), .o_seg(w_seg2));
    seg7_decode u_dec1 (.i_digit(w_next_scratch[7:4]),  .o_seg(w_seg1));
    seg7_decode u_dec0 (.i_digit(w_next_scratch[3:0]),  .o_seg(w_seg0));

`ifdef SUM_DISPLAY_BLANK_EN
    logic w_blank2;
    logic w_blank1;
    assign w_blank2 = (w_next_scratch[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (w_next_scratch[7:4] == 4'd0);
    assign w_hex2   = w_blank2 ? c_SEG_BLANK : w_seg2;
    assign w_hex1   = w_blank1 ? c_SEG_BLANK : w_seg1;
`else
    assign w_hex2   = w_seg2;
    assign w_hex1   = w_seg1;
`endif
    assign w_hex0   = w_seg0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_hex2    <= c_HEX_HI_RST;
            r_hex1    <= c_HEX_HI_RST;
            r_hex0    <= c_SEG_0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift   <= value;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_bcd   <= w_next_scratch;
                        r_hex2  <= w_hex2;
                        r_hex1  <= w_hex1;
                        r_hex0  <= w_hex0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign HEX2 = r_hex2;
    assign HEX1 = r_hex1;
    assign HEX0 = r_hex0;

endmodule
`default_nettype wire
